bcd_decimal_adder: RTL and testbench



---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_digit_adder.sv | 24 ++
 rtl/bcd_decimal_adder.sv | 53 +++++
 tb/tb_bcd_decimal_adder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the packed-BCD adder datapath.
// One BCD digit is a 4-bit nibble holding 0..9.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry.
// Out-of-range nibbles still go through the same +6 correction, and are flagged.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout,
    output logic       bad
);

    logic [4:0] t;

    always_comb begin
        t    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (t > {1'b0, BCD_MAX});
        // (t + 6) mod 16 only needs the low nibble of t
        s    = cout ? (t[3:0] + BCD_CORR) : t[3:0];
        bad  = (a > BCD_MAX) || (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_decimal_adder.sv
// Registered multi-digit BCD adder: ripple-carry digit chain, 1-cycle latency.
// Outputs hold their last result while no new operands arrive.
module bcd_decimal_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [BCD_W*DIGITS-1:0] augend,
    input  logic [BCD_W*DIGITS-1:0] addend,
    input  logic                    Cin,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    Cout,
    output logic                    out_valid,
    output logic                    err
);

    logic [DIGITS:0]         carry;
    logic [DIGITS-1:0]       bad;
    logic [BCD_W*DIGITS-1:0] sum_d;

    assign carry[0] = Cin;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_adder u_digit (
            .a    (augend[i*BCD_W +: BCD_W]),
            .b    (addend[i*BCD_W +: BCD_W]),
            .cin  (carry[i]),
            .s    (sum_d[i*BCD_W +: BCD_W]),
            .cout (carry[i+1]),
            .bad  (bad[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            Cout      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_d;
                Cout <= carry[DIGITS];
                err  <= |bad;
            end
        end
    end

endmodule

// File: tb/tb_bcd_decimal_adder.sv
// Scoreboard bench for bcd_decimal_adder: one 1-digit and one 2-digit instance.
// Expected results are queued at issue time and popped when out_valid shows.
module tb_bcd_decimal_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v1 = 1'b0, c1 = 1'b0;
    logic [3:0] a1 = '0, b1 = '0;
    logic [3:0] s1;
    logic       co1, ov1, e1;

    logic       v2 = 1'b0, c2 = 1'b0;
    logic [7:0] a2 = '0, b2 = '0;
    logic [7:0] s2;
    logic       co2, ov2, e2;

    bcd_decimal_adder #(.DIGITS(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1),
        .augend(a1), .addend(b1), .Cin(c1),
        .sum(s1), .Cout(co1), .out_valid(ov1), .err(e1)
    );

    bcd_decimal_adder #(.DIGITS(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2),
        .augend(a2), .addend(b2), .Cin(c2),
        .sum(s2), .Cout(co2), .out_valid(ov2), .err(e2)
    );

    int compared = 0;
    int mismatched = 0;
    int vcnt1 = 0;

    logic [5:0] q1[$];
    logic [9:0] q2[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a result is presented
    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            vcnt1++;
            if (q1.size() == 0) chk("u1_unexpected_valid", 1, 0);
            else chk("u1_result", {26'd0, e1, co1, s1}, {26'd0, q1.pop_front()});
        end
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) chk("u2_unexpected_valid", 1, 0);
            else chk("u2_result", {22'd0, e2, co2, s2}, {22'd0, q2.pop_front()});
        end
    end

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] es, input logic ec, input logic ee);
        @(negedge clk);
        rst = 1'b0; v1 = 1'b1; a1 = a; b1 = b; c1 = c;
        q1.push_back({ee, ec, es});
    endtask

    task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic ee);
        @(negedge clk);
        rst = 1'b0; v2 = 1'b1; a2 = a; b2 = b; c2 = c;
        q2.push_back({ee, ec, es});
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    int base;
    int t;

    initial begin
        // Reset with valid operands present: must not produce a result
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1; a1 = 4'h7; b1 = 4'h8; c1 = 1'b1;
        v2 = 1'b1; a2 = 8'h56; b2 = 8'h78; c2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_u1", {ov1, e1, co1, s1}, 7'd0);
        chk("rst_u2", {ov2, e2, co2, s2}, 11'd0);
        v1 = 1'b0; v2 = 1'b0;

        op1(4'd9, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
        op1(4'd8, 4'd1, 1'b0, 4'd9, 1'b0, 1'b0);
        op1(4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);
        op1(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        op1(4'd5, 4'd4, 1'b1, 4'd0, 1'b1, 1'b0);
        op1(4'hC, 4'h0, 1'b0, 4'd2, 1'b1, 1'b1);
        op1(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);
        op1(4'hF, 4'hF, 1'b1, 4'd5, 1'b1, 1'b1);
        op1(4'hA, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1);
        op1(4'd2, 4'hB, 1'b0, 4'd3, 1'b1, 1'b1);
        idle();

        // Exhaustive valid-digit sweep: expected is decimal tens/ones
        for (int a = 0; a < 10; a++)
            for (int b = 0; b < 10; b++)
                for (int c = 0; c < 2; c++) begin
                    t = a + b + c;
                    op1(4'(a), 4'(b), 1'(c), 4'(t % 10), (t >= 10), 1'b0);
                end
        idle();

        op2(8'h99, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op2(8'h45, 8'h55, 1'b1, 8'h01, 1'b1, 1'b0);
        op2(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        op2(8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0);
        op2(8'h1F, 8'h00, 1'b0, 8'h25, 1'b0, 1'b1);
        op2(8'h38, 8'h27, 1'b0, 8'h65, 1'b0, 1'b0);
        idle();

        // Streaming: exactly four results, then outputs hold
        idle();
        base = vcnt1;
        op1(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
        op1(4'd7, 4'd7, 1'b0, 4'd4, 1'b1, 1'b0);
        op1(4'd9, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
        op1(4'd2, 4'd3, 1'b1, 4'd6, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("stream_count", vcnt1 - base, 4);
        chk("hold_u1", {ov1, e1, co1, s1}, {1'b0, 1'b0, 1'b0, 4'd6});
        @(negedge clk);
        chk("hold_u1_again", {ov1, e1, co1, s1}, {1'b0, 1'b0, 1'b0, 4'd6});
        chk("hold_u2", {ov2, e2, co2, s2}, {1'b0, 1'b0, 1'b0, 8'h65});

        // Reset mid-stream drops the operation presented with rst
        op1(4'd4, 4'd4, 1'b0, 4'd8, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1; a1 = 4'd9; b1 = 4'd9; c1 = 1'b1;
        @(negedge clk);
        chk("midrst_u1", {ov1, e1, co1, s1}, 7'd0);
        chk("midrst_u2", {ov2, e2, co2, s2}, 11'd0);
        rst = 1'b0; v1 = 1'b0;
        op1(4'd6, 4'd7, 1'b0, 4'd3, 1'b1, 1'b0);
        idle();
        idle();
        idle();

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
